// File: rtl/cb_sequencer_pkg.sv
// Shared types and constants for the CB-prefix sequencer.
// The CB_CYCLE_ACCURATE_EN build adds FINISH-state pacing in cb_sequencer.
package cb_sequencer_pkg;

  typedef enum logic [3:0] {
    alu_NOP  = 4'd0,
    alu_RLC  = 4'd1,
    alu_RRC  = 4'd2,
    alu_RL   = 4'd3,
    alu_RR   = 4'd4,
    alu_SLA  = 4'd5,
    alu_SRA  = 4'd6,
    alu_SWAP = 4'd7,
    alu_SRL  = 4'd8
  } alu_op_t;

  typedef enum logic [2:0] {
    CB_IDLE   = 3'd0,
    CB_MEM_RD = 3'd1,
    CB_EXEC   = 3'd2,
    CB_MEM_WR = 3'd3,
    CB_FINISH = 3'd4
  } cb_state_t;

  localparam logic [2:0] CB_IDX_HL = 3'd6;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] GRP_SHIFT = 2'b00;
  localparam logic [1:0] GRP_BIT   = 2'b01;
  localparam logic [1:0] GRP_RES   = 2'b10;
  localparam logic [1:0] GRP_SET   = 2'b11;

  // y field of the shift/rotate group maps onto consecutive ALU opcodes
  function automatic alu_op_t shift_op(input logic [2:0] y);
    return alu_op_t'({1'b0, y} + 4'd1);
  endfunction

endpackage

// File: rtl/cb_sequencer_bitop.sv
// Combinational BIT/RES/SET unit; shift-group opcodes pass operand and flags through.
module cb_bitop
  import cb_sequencer_pkg::*;
(
  input  logic [7:0] operand,
  input  logic [2:0] y,
  input  logic [1:0] grp,
  input  logic [3:0] flags_in,
  output logic [7:0] result,
  output logic [3:0] flags
);

  logic [7:0] mask;

  assign mask = 8'd1 << y;

  always_comb begin
    result = operand;
    flags  = flags_in;
    case (grp)
      GRP_BIT: begin
        flags[FLAG_Z] = ~operand[y];
        flags[FLAG_N] = 1'b0;
        flags[FLAG_H] = 1'b1;
        flags[FLAG_C] = flags_in[FLAG_C];
      end
      GRP_RES: result = operand & ~mask;
      GRP_SET: result = operand | mask;
      default: ;
    endcase
  end

endmodule

// File: rtl/cb_sequencer.sv
// Multi-cycle executor for CB-prefixed instructions (rotate/shift/SWAP/BIT/RES/SET).
// Define CB_CYCLE_ACCURATE_EN to pace done/busy to real M-cycle counts via FINISH.
//
// state  | meaning
// IDLE   | waiting for start
// MEM_RD | fetching the (HL) operand
// EXEC   | computing result, register write-back, flag update
// MEM_WR | writing result back to (HL)
// FINISH | padding to M-cycle count (cycle-accurate build only)
module cb_sequencer
  import cb_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cb_opcode,
  output logic        busy,
  output logic        done,
  output logic [2:0]  reg_rsel,
  input  logic [7:0]  reg_rdata,
  input  logic [15:0] hl,
  output logic        reg_we,
  output logic [2:0]  reg_wsel,
  output logic [7:0]  reg_wdata,
  input  logic [3:0]  flags_in,
  output logic        flags_we,
  output logic [3:0]  flags_out,
  output alu_op_t     alu_op,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  cb_state_t  state_q, state_d;
  logic [7:0] op_q, operand_q, result_q;
  logic [1:0] grp;
  logic [2:0] y, r;
  logic       to_hl, is_bit;
  logic [7:0] operand, bit_result, exec_result;
  logic [3:0] bit_flags;
  logic       complete;

  assign grp   = op_q[7:6];
  assign y     = op_q[5:3];
  assign r     = op_q[2:0];
  assign to_hl  = (r == CB_IDX_HL);
  assign is_bit = (grp == GRP_BIT);

  assign operand     = to_hl ? operand_q : reg_rdata;
  assign exec_result = (grp == GRP_SHIFT) ? alu_result : bit_result;

  cb_bitop u_bitop (
    .operand  (operand),
    .y        (y),
    .grp      (grp),
    .flags_in (flags_in),
    .result   (bit_result),
    .flags    (bit_flags)
  );

`ifdef CB_CYCLE_ACCURATE_EN
  localparam cb_state_t DONE_STATE = CB_FINISH;
  logic [1:0] wait_q;

  // Down-counter loaded with (minimum M-cycles - 1); FINISH releases at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 2'd0;
    end else if (state_q == CB_IDLE) begin
      if (start) begin
        if (cb_opcode[2:0] != CB_IDX_HL)      wait_q <= 2'd1;
        else if (cb_opcode[7:6] == GRP_BIT)   wait_q <= 2'd2;
        else                                  wait_q <= 2'd3;
      end
    end else if (wait_q != 2'd0) begin
      wait_q <= wait_q - 2'd1;
    end
  end
`else
  localparam cb_state_t DONE_STATE = CB_IDLE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CB_IDLE;
      op_q      <= 8'h00;
      operand_q <= 8'h00;
      result_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == CB_IDLE && start)   op_q      <= cb_opcode;
      if (state_q == CB_MEM_RD && mem_ack) operand_q <= mem_rdata;
      if (state_q == CB_EXEC)            result_q  <= exec_result;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CB_IDLE:   if (start) state_d = (cb_opcode[2:0] == CB_IDX_HL) ? CB_MEM_RD : CB_EXEC;
      CB_MEM_RD: if (mem_ack) state_d = CB_EXEC;
      CB_EXEC:   state_d = (!to_hl || is_bit) ? DONE_STATE : CB_MEM_WR;
      CB_MEM_WR: if (mem_ack) state_d = DONE_STATE;
`ifdef CB_CYCLE_ACCURATE_EN
      CB_FINISH: if (wait_q == 2'd0) state_d = CB_IDLE;
`endif
      default:   state_d = CB_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != CB_IDLE);
    reg_rsel  = r;
    reg_we    = 1'b0;
    reg_wsel  = 3'd0;
    reg_wdata = 8'h00;
    flags_we  = 1'b0;
    flags_out = 4'h0;
    alu_op    = alu_NOP;
    alu_b     = 8'h00;
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    complete  = 1'b0;
    case (state_q)
      CB_MEM_RD: begin
        mem_addr = hl;
        mem_rd   = 1'b1;
      end
      CB_EXEC: begin
        if (grp == GRP_SHIFT) begin
          alu_op    = shift_op(y);
          alu_b     = operand;
          flags_we  = 1'b1;
          flags_out = alu_flags;
        end else if (is_bit) begin
          flags_we  = 1'b1;
          flags_out = bit_flags;
        end
        if (!to_hl && !is_bit) begin
          reg_we    = 1'b1;
          reg_wsel  = r;
          reg_wdata = exec_result;
        end
        complete = !to_hl || is_bit;
      end
      CB_MEM_WR: begin
        mem_addr  = hl;
        mem_wr    = 1'b1;
        mem_wdata = result_q;
        complete  = mem_ack;
      end
      default: ;
    endcase
`ifdef CB_CYCLE_ACCURATE_EN
    done = (state_q == CB_FINISH) && (wait_q == 2'd0);
`else
    done = complete;
`endif
  end

endmodule

// File: tb/tb_cb_sequencer.sv
// Directed self-checking bench for cb_sequencer (default build) with a small ALU model.
module tb_cb_sequencer;
  import cb_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  cb_opcode;
  logic        busy, done;
  logic [2:0]  reg_rsel;
  logic [7:0]  reg_rdata;
  logic [15:0] hl;
  logic        reg_we;
  logic [2:0]  reg_wsel;
  logic [7:0]  reg_wdata;
  logic [3:0]  flags_in;
  logic        flags_we;
  logic [3:0]  flags_out;
  alu_op_t     alu_op;
  logic [7:0]  alu_b, alu_result;
  logic [3:0]  alu_flags;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cb_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cb_opcode(cb_opcode),
    .busy(busy), .done(done), .reg_rsel(reg_rsel), .reg_rdata(reg_rdata),
    .hl(hl), .reg_we(reg_we), .reg_wsel(reg_wsel), .reg_wdata(reg_wdata),
    .flags_in(flags_in), .flags_we(flags_we), .flags_out(flags_out),
    .alu_op(alu_op), .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Reference ALU for the shift/rotate group; C comes from flags_in for RL/RR.
  always_comb begin
    logic c;
    c = 1'b0;
    alu_result = 8'h00;
    case (alu_op)
      alu_RLC:  begin alu_result = {alu_b[6:0], alu_b[7]};      c = alu_b[7]; end
      alu_RRC:  begin alu_result = {alu_b[0], alu_b[7:1]};      c = alu_b[0]; end
      alu_RL:   begin alu_result = {alu_b[6:0], flags_in[0]};   c = alu_b[7]; end
      alu_RR:   begin alu_result = {flags_in[0], alu_b[7:1]};   c = alu_b[0]; end
      alu_SLA:  begin alu_result = {alu_b[6:0], 1'b0};          c = alu_b[7]; end
      alu_SRA:  begin alu_result = {alu_b[7], alu_b[7:1]};      c = alu_b[0]; end
      alu_SWAP: begin alu_result = {alu_b[3:0], alu_b[7:4]};    c = 1'b0;     end
      alu_SRL:  begin alu_result = {1'b0, alu_b[7:1]};          c = alu_b[0]; end
      default:  ;
    endcase
    alu_flags = {(alu_result == 8'h00), 1'b0, 1'b0, c};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cb_opcode = 8'h00; reg_rdata = 8'h00; hl = 16'h0000;
    flags_in = 4'h0; mem_rdata = 8'h00; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",   16'(busy),   16'd0);
    chk("rst_done",   16'(done),   16'd0);
    chk("rst_alu_op", 16'(alu_op), 16'(alu_NOP));
    chk("rst_mem_rd", 16'(mem_rd), 16'd0);
    chk("rst_reg_we", 16'(reg_we), 16'd0);
    chk("rst_addr",   mem_addr,    16'h0000);
    rst = 1'b0;

    // RLC B
    @(negedge clk); start = 1'b1; cb_opcode = 8'h00; reg_rdata = 8'h85; flags_in = 4'h0;
    @(negedge clk); start = 1'b0; #1;
    chk("rlc_alu_op",  16'(alu_op),    16'(alu_RLC));
    chk("rlc_alu_b",   16'(alu_b),     16'h85);
    chk("rlc_reg_we",  16'(reg_we),    16'd1);
    chk("rlc_wsel",    16'(reg_wsel),  16'd0);
    chk("rlc_wdata",   16'(reg_wdata), 16'h0B);
    chk("rlc_fwe",     16'(flags_we),  16'd1);
    chk("rlc_flags",   16'(flags_out), 16'b0001);
    chk("rlc_done",    16'(done),      16'd1);
    @(negedge clk); #1;
    chk("rlc_idle_busy", 16'(busy), 16'd0);
    chk("rlc_idle_done", 16'(done), 16'd0);

    // SWAP (HL) with two wait cycles on the read
    @(negedge clk); start = 1'b1; cb_opcode = 8'h36; hl = 16'hC000; mem_rdata = 8'hF0;
    @(negedge clk); start = 1'b0; #1;
    chk("swap_rd1",   16'(mem_rd), 16'd1);
    chk("swap_addr",  mem_addr,    16'hC000);
    chk("swap_busy",  16'(busy),   16'd1);
    @(negedge clk); #1;
    chk("swap_rd2",   16'(mem_rd), 16'd1);
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("swap_rd3",   16'(mem_rd), 16'd1);
    chk("swap_nowr",  16'(mem_wr), 16'd0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("swap_alu_op", 16'(alu_op),    16'(alu_SWAP));
    chk("swap_alu_b",  16'(alu_b),     16'hF0);
    chk("swap_fwe",    16'(flags_we),  16'd1);
    chk("swap_flags",  16'(flags_out), 16'b0000);
    chk("swap_reg_we", 16'(reg_we),    16'd0);
    chk("swap_ex_done",16'(done),      16'd0);
    chk("swap_ex_rd",  16'(mem_rd),    16'd0);
    @(negedge clk); #1;
    chk("swap_wr",     16'(mem_wr),    16'd1);
    chk("swap_waddr",  mem_addr,       16'hC000);
    chk("swap_wdata",  16'(mem_wdata), 16'h0F);
    chk("swap_wr_nodone", 16'(done),   16'd0);
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("swap_done",   16'(done),   16'd1);
    chk("swap_wr_ack", 16'(mem_wr), 16'd1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("swap_end_busy", 16'(busy), 16'd0);

    // stray ack while idle
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("idle_ack_rd", 16'(mem_rd), 16'd0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("idle_ack_busy", 16'(busy), 16'd0);

    // BIT 7,A
    @(negedge clk); start = 1'b1; cb_opcode = 8'h7F; reg_rdata = 8'h7F; flags_in = 4'b0001;
    @(negedge clk); start = 1'b0; #1;
    chk("bit7_fwe",    16'(flags_we),  16'd1);
    chk("bit7_flags",  16'(flags_out), 16'b1011);
    chk("bit7_reg_we", 16'(reg_we),    16'd0);
    chk("bit7_alu_op", 16'(alu_op),    16'(alu_NOP));
    chk("bit7_done",   16'(done),      16'd1);

    // BIT 0,(HL): finishes in EXEC with no memory write
    @(negedge clk); start = 1'b1; cb_opcode = 8'h46; mem_rdata = 8'h01; flags_in = 4'h0;
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; #1;
    chk("bithl_rd", 16'(mem_rd), 16'd1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("bithl_flags", 16'(flags_out), 16'b0010);
    chk("bithl_done",  16'(done),      16'd1);
    chk("bithl_nowr",  16'(mem_wr),    16'd0);
    @(negedge clk); #1;
    chk("bithl_idle", 16'(busy), 16'd0);

    // SET 0,(HL), zero-wait memory
    @(negedge clk); start = 1'b1; cb_opcode = 8'hC6; mem_rdata = 8'h00;
    @(negedge clk); start = 1'b0; mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("set_ex_fwe",  16'(flags_we), 16'd0);
    chk("set_ex_alu",  16'(alu_op),   16'(alu_NOP));
    chk("set_ex_done", 16'(done),     16'd0);
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("set_wdata",  16'(mem_wdata), 16'h01);
    chk("set_wr_fwe", 16'(flags_we),  16'd0);
    chk("set_done",   16'(done),      16'd1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("set_idle", 16'(busy), 16'd0);

    // reset during MEM_WR of RLC (HL)
    @(negedge clk); start = 1'b1; cb_opcode = 8'h06; mem_rdata = 8'h80;
    @(negedge clk); start = 1'b0; mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("rstwr_pre", 16'(mem_wr), 16'd1);
    rst = 1'b1; #1;
    chk("rstwr_wr",   16'(mem_wr), 16'd0);
    chk("rstwr_busy", 16'(busy),   16'd0);
    chk("rstwr_done", 16'(done),   16'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstwr_after", 16'(mem_wr), 16'd0);
    @(negedge clk); start = 1'b1; cb_opcode = 8'h00; reg_rdata = 8'h01; flags_in = 4'h0;
    @(negedge clk); start = 1'b0; #1;
    chk("post_rst_wdata", 16'(reg_wdata), 16'h02);
    chk("post_rst_we",    16'(reg_we),    16'd1);
    chk("post_rst_flags", 16'(flags_out), 16'b0000);
    chk("post_rst_done",  16'(done),      16'd1);

    // RES 1,(HL) with a start pulse during MEM_RD
    @(negedge clk); start = 1'b1; cb_opcode = 8'h8E; mem_rdata = 8'hFF;
    @(negedge clk); start = 1'b1; cb_opcode = 8'h10; #1;
    chk("ign_rsel1", 16'(reg_rsel), 16'd6);
    chk("ign_rd",    16'(mem_rd),   16'd1);
    @(negedge clk); start = 1'b0; mem_ack = 1'b1; #1;
    chk("ign_rsel2", 16'(reg_rsel), 16'd6);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("ign_alu_op", 16'(alu_op),   16'(alu_NOP));
    chk("ign_fwe",    16'(flags_we), 16'd0);
    chk("ign_nowr",   16'(mem_wr),   16'd0);
    @(negedge clk); mem_ack = 1'b1; #1;
    chk("ign_wdata", 16'(mem_wdata), 16'hFD);
    chk("ign_done",  16'(done),      16'd1);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("ign_idle_busy", 16'(busy), 16'd0);
    chk("ign_idle_done", 16'(done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
